// File: rtl/layer_norm_stream.sv
// Streaming LayerNorm / RMSNorm over rows of EMB_DIM signed Q(FRAC) elements.
// One pass gathers sum and sum of squares. Then an iterative sqrt and an
// iterative reciprocal give inv_std. Each column is then normalised, scaled by
// gamma, shifted by beta and saturated back to DATA_WIDTH.
module layer_norm_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 8,
  parameter int EMB_DIM    = 8,
  parameter int EPS        = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mode,
  input  logic [DATA_WIDTH*EMB_DIM-1:0]    gamma_in,
  input  logic [DATA_WIDTH*EMB_DIM-1:0]    beta_in,
  input  logic signed [DATA_WIDTH-1:0]     in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic signed [DATA_WIDTH-1:0]     out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy
);
  localparam int DW   = DATA_WIDTH;
  localparam int LG   = $clog2(EMB_DIM);
  localparam int SW   = DW + LG;          // sum width
  localparam int QW   = 2 * DW + LG;      // sum-of-squares width
  localparam int IW   = 2 * DW;           // radicand / inv_std width
  localparam int PW   = DW + 1 + IW + 1;  // diff * inv_std
  localparam int UW   = PW + DW;          // t * gamma
  localparam int IT_W = $clog2(IW);

  typedef enum logic [2:0] {S_LOAD, S_STAT, S_SQRT, S_RECIP, S_PREP, S_OUT} state_t;

  state_t                  state, state_nxt;
  logic [LG-1:0]           col;
  logic [IT_W-1:0]         iter;
  logic signed [SW-1:0]    sum;
  logic [QW-1:0]           sumsq;
  logic signed [DW-1:0]    row_buf [EMB_DIM];
  logic [DW*EMB_DIM-1:0]   gamma_r, beta_r;
  logic                    mode_r;
  logic signed [DW-1:0]    mean_r;
  logic [IW-1:0]           sq_rad;
  logic [DW+1:0]           sq_rem;
  logic [DW-1:0]           sq_root;
  logic [IW-1:0]           dv;      // dividend shifts out, quotient (inv_std) shifts in
  logic [DW-1:0]           dv_rem;

  logic                    in_fire, out_fire;
  logic signed [IW-1:0]    x_sq;
  logic signed [DW-1:0]    mean_c;
  logic [IW-1:0]           ex2_c;
  logic signed [IW-1:0]    msq_c;
  logic signed [IW:0]      var_c;
  logic [IW-1:0]           d_c;
  logic [DW+3:0]           sq_sh, sq_trial, sq_diff;
  logic                    sq_ge;
  logic [DW:0]             dv_sh, dv_diff;
  logic                    dv_ge;
  logic [LG-1:0]           sel;
  logic signed [DW:0]      diff_c;
  logic signed [PW-1:0]    prod_c, t_c;
  logic signed [DW-1:0]    g_c, b_c;
  logic signed [UW-1:0]    u_c;

  function automatic logic signed [DW-1:0] sat(input logic signed [UW-1:0] v);
    logic signed [UW-1:0] hi, lo;
    hi = $signed({{(UW-DW+1){1'b0}}, {(DW-1){1'b1}}});
    lo = $signed({{(UW-DW+1){1'b1}}, {(DW-1){1'b0}}});
    if (v > hi)      sat = hi[DW-1:0];
    else if (v < lo) sat = lo[DW-1:0];
    else             sat = v[DW-1:0];
  endfunction

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign x_sq     = IW'(in_data) * IW'(in_data);

  // Row statistics: mean, variance clamped at zero, plus epsilon
  always_comb begin
    mean_c = mode_r ? '0 : DW'(sum >>> LG);
    ex2_c  = IW'(sumsq >> LG);
    msq_c  = IW'(mean_c) * IW'(mean_c);
    var_c  = $signed({1'b0, ex2_c}) - (IW+1)'(msq_c);
    d_c    = var_c[IW] ? IW'(EPS) : var_c[IW-1:0] + IW'(EPS);
  end

  // One restoring-sqrt step and one restoring-division step
  always_comb begin
    sq_sh    = {sq_rem, sq_rad[IW-1 -: 2]};
    sq_trial = {2'b00, sq_root, 2'b01};
    sq_ge    = (sq_sh >= sq_trial);
    sq_diff  = sq_sh - sq_trial;
    dv_sh    = {dv_rem, dv[IW-1]};
    dv_ge    = (dv_sh >= {1'b0, sq_root});
    dv_diff  = dv_sh - {1'b0, sq_root};
  end

  // Normalise the column about to be presented (column 0 in S_PREP, next column in S_OUT)
  always_comb begin
    sel    = (state == S_OUT) ? col + LG'(1) : col;
    g_c    = $signed(gamma_r[sel*DW +: DW]);
    b_c    = $signed(beta_r[sel*DW +: DW]);
    diff_c = (DW+1)'(row_buf[sel]) - (DW+1)'(mean_r);
    prod_c = PW'(diff_c) * PW'($signed({1'b0, dv}));
    t_c    = prod_c >>> FRAC;
    u_c    = ((UW'(t_c) * UW'(g_c)) >>> FRAC) + UW'(b_c);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (in_fire && col == LG'(EMB_DIM-1)) state_nxt = S_STAT;
      S_STAT:  state_nxt = S_SQRT;
      S_SQRT:  if (iter == IT_W'(DW-1)) state_nxt = S_RECIP;
      S_RECIP: if (iter == IT_W'(IW-1)) state_nxt = S_PREP;
      S_PREP:  state_nxt = S_OUT;
      S_OUT:   if (out_fire && col == LG'(EMB_DIM-1)) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (state == S_LOAD);
    out_valid = (state == S_OUT);
    out_last  = (state == S_OUT) && (col == LG'(EMB_DIM-1));
    busy      = !((state == S_LOAD) && (col == '0));
  end

  // Counters and accumulators; the first element of a row restarts the sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      iter  <= '0;
      sum   <= '0;
      sumsq <= '0;
    end else begin
      case (state)
        S_LOAD: if (in_fire) begin
          col   <= col + LG'(1);
          sum   <= ((col == '0) ? '0 : sum) + SW'(in_data);
          sumsq <= ((col == '0) ? '0 : sumsq) + QW'($unsigned(x_sq));
        end
        S_STAT:  iter <= '0;
        S_SQRT:  iter <= (iter == IT_W'(DW-1)) ? '0 : iter + IT_W'(1);
        S_RECIP: iter <= (iter == IT_W'(IW-1)) ? '0 : iter + IT_W'(1);
        S_OUT:   if (out_fire) col <= col + LG'(1);
        default: ;
      endcase
    end
  end

  // Row buffer, latched coefficients and the sqrt / reciprocal iterations
  always_ff @(posedge clk) begin
    case (state)
      S_LOAD: if (in_fire) begin
        row_buf[col] <= in_data;
        if (col == '0) begin
          mode_r  <= mode;
          gamma_r <= gamma_in;
          beta_r  <= beta_in;
        end
      end
      S_STAT: begin
        mean_r  <= mean_c;
        sq_rad  <= d_c;
        sq_rem  <= '0;
        sq_root <= '0;
      end
      S_SQRT: begin
        sq_rad  <= sq_rad << 2;
        sq_rem  <= (DW+2)'(sq_ge ? sq_diff : sq_sh);
        sq_root <= {sq_root[DW-2:0], sq_ge};
        if (iter == IT_W'(DW-1)) begin
          dv     <= IW'(1) << (2 * FRAC);
          dv_rem <= '0;
        end
      end
      S_RECIP: begin
        dv     <= {dv[IW-2:0], dv_ge};
        dv_rem <= DW'(dv_ge ? dv_diff : dv_sh);
      end
      default: ;
    endcase
  end

  // Registered output element, refreshed only when a new column is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               out_data <= '0;
    else if (state == S_PREP)                                 out_data <= sat(u_c);
    else if (out_fire && col != LG'(EMB_DIM-1))               out_data <= sat(u_c);
  end

endmodule

// File: tb/tb_layer_norm_stream.sv
// Directed bench for layer_norm_stream at default parameters.
module tb_layer_norm_stream;
  logic               clk, rst_n, mode;
  logic [127:0]       gamma_in, beta_in;
  logic signed [15:0] in_data, out_data;
  logic               in_valid, in_ready, out_valid, out_ready, out_last, busy;
  int                 n_assert = 0;
  int                 n_fail = 0;
  int                 lat;

  layer_norm_stream dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .gamma_in(gamma_in), .beta_in(beta_in),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [15:0] v);
    for (int j = 0; j < 8; j++) rep[j*16 +: 16] = v;
  endfunction

  function automatic logic [127:0] alt(input logic [15:0] a, input logic [15:0] b);
    for (int j = 0; j < 8; j++) alt[j*16 +: 16] = (j % 2 == 0) ? a : b;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Sends the first n elements of a row; scrambles mode/gamma/beta after the first one.
  task automatic send_row(input string tag, input logic [127:0] row, input logic m,
                          input logic [127:0] g, input logic [127:0] b, input int n);
    int guard;
    mode = m; gamma_in = g; beta_in = b;
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1;
      in_data  = row[j*16 +: 16];
      guard = 0;
      while (!in_ready && guard < 200) begin step(); guard++; end
      chk($sformatf("%s_rdy%0d", tag, j), {31'd0, in_ready}, 32'd1);
      step();
      if (j == 0) begin
        chk($sformatf("%s_busy", tag), {31'd0, busy}, 32'd1);
        mode = ~m; gamma_in = ~g; beta_in = ~b;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_first(input string tag, output int cnt);
    cnt = 0;
    out_ready = 1'b0;
    while (!out_valid && cnt < 200) begin step(); cnt++; end
    chk($sformatf("%s_outvld", tag), {31'd0, out_valid}, 32'd1);
  endtask

  // Collects one row; bp selects the 1,0,0,1 out_ready pattern.
  task automatic recv_row(input string tag, input logic [127:0] exp, input bit bp);
    int idx = 0;
    int k = 0;
    int guard = 0;
    while (idx < 8 && guard < 400) begin
      out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (out_valid) begin
        chk($sformatf("%s_d%0d", tag, idx), {16'd0, $unsigned(out_data)}, {16'd0, exp[idx*16 +: 16]});
        chk($sformatf("%s_l%0d", tag, idx), {31'd0, out_last}, (idx == 7) ? 32'd1 : 32'd0);
        chk($sformatf("%s_ir%0d", tag, idx), {31'd0, in_ready}, 32'd0);
        if (out_ready) idx++;
        k++;
      end
      step();
      guard++;
    end
    out_ready = 1'b0;
    chk($sformatf("%s_count", tag), idx, 32'd8);
    chk($sformatf("%s_ready_after", tag), {31'd0, in_ready}, 32'd1);
    chk($sformatf("%s_vld_after", tag), {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    clk = 0; rst_n = 0; mode = 0; gamma_in = '0; beta_in = '0;
    in_data = '0; in_valid = 0; out_ready = 0;
    repeat (3) step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", {16'd0, $unsigned(out_data)}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1;
    step();

    // LN, constant row of 1.0: variance 0, inv_std 65536, output equals beta
    send_row("t1", rep(16'h0100), 1'b0, rep(16'h0100), rep(16'h0040), 8);
    wait_first("t1", lat);
    chk("t1_latency", lat, 32'd50);
    recv_row("t1", rep(16'h0040), 1'b0);

    // LN, alternating +1.0/-1.0: std 256, inv_std 256
    send_row("t2", alt(16'h0100, 16'hFF00), 1'b0, rep(16'h0100), rep(16'h0000), 8);
    wait_first("t2", lat);
    recv_row("t2", alt(16'h0100, 16'hFF00), 1'b0);

    // RMS, constant 2.0: std 512, inv_std 128, outputs 1.0
    send_row("t3", rep(16'h0200), 1'b1, rep(16'h0100), rep(16'h0000), 8);
    wait_first("t3", lat);
    recv_row("t3", rep(16'h0100), 1'b0);

    // Same row in LN mode normalises to zero
    send_row("t3b", rep(16'h0200), 1'b0, rep(16'h0100), rep(16'h0000), 8);
    wait_first("t3b", lat);
    recv_row("t3b", rep(16'h0000), 1'b0);

    // Saturation: +1.0*gamma+beta overflows, -1.0*gamma+beta cancels
    send_row("t4", alt(16'h0100, 16'hFF00), 1'b0, rep(16'h7FFF), rep(16'h7FFF), 8);
    wait_first("t4", lat);
    recv_row("t4", alt(16'h7FFF, 16'h0000), 1'b0);

    // Backpressure with next row's first element already offered
    send_row("t5", alt(16'h0100, 16'hFF00), 1'b0, rep(16'h0200), rep(16'h0010), 8);
    in_valid = 1'b1;
    in_data  = 16'h0100;
    wait_first("t5", lat);
    chk("t5_latency", lat, 32'd50);
    recv_row("t5", alt(16'h0210, 16'hFE10), 1'b1);

    // Back-to-back row after the stall
    send_row("t6", rep(16'h0100), 1'b0, rep(16'h0100), rep(16'h0040), 8);
    wait_first("t6", lat);
    recv_row("t6", rep(16'h0040), 1'b0);

    // Abort a row with reset after 5 elements, then send a fresh row
    send_row("t7a", rep(16'h0300), 1'b0, rep(16'h0100), rep(16'h0000), 5);
    chk("t7_busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 0;
    #1;
    chk("t7_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t7_rst_busy", {31'd0, busy}, 32'd0);
    chk("t7_rst_out_data", {16'd0, $unsigned(out_data)}, 32'd0);
    chk("t7_rst_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst_n = 1;
    step();
    send_row("t7", alt(16'h0100, 16'hFF00), 1'b0, rep(16'h0100), rep(16'h0000), 8);
    wait_first("t7", lat);
    chk("t7_latency", lat, 32'd50);
    recv_row("t7", alt(16'h0100, 16'hFF00), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
